// File: rtl/regfile_sb.sv
// Multi-ported register file with a busy scoreboard for pending destinations.
// Reads are combinational with write-through bypass; register 0 is hardwired to zero.
module regfile_sb #(
    parameter int unsigned READ_PORTS  = 2,
    parameter int unsigned WRITE_PORTS = 2,
    parameter int unsigned RESV_PORTS  = 2,
    parameter int unsigned NREGS       = 32,
    parameter int unsigned XLEN        = 64,
    localparam int unsigned AW         = $clog2(NREGS)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [READ_PORTS-1:0][AW-1:0]       ra1,
    input  logic [READ_PORTS-1:0][AW-1:0]       ra2,
    output logic [READ_PORTS-1:0][XLEN-1:0]     rd1,
    output logic [READ_PORTS-1:0][XLEN-1:0]     rd2,
    output logic [READ_PORTS-1:0]               rbusy1,
    output logic [READ_PORTS-1:0]               rbusy2,
    input  logic [WRITE_PORTS-1:0][AW-1:0]      wa,
    input  logic [WRITE_PORTS-1:0]              wvalid,
    input  logic [WRITE_PORTS-1:0][XLEN-1:0]    wd,
    input  logic [RESV_PORTS-1:0][AW-1:0]       resv_addr,
    input  logic [RESV_PORTS-1:0]               resv_valid,
    input  logic                                flush,
    output logic [NREGS-1:0]                    busy_vec
);

    logic [XLEN-1:0]  r_mem [NREGS];
    logic [NREGS-1:0] r_busy;

    logic [NREGS-1:0] w_wr_hit;
    logic [XLEN-1:0]  w_wr_data [NREGS];
    logic [NREGS-1:0] w_resv_hit;

    // Per-register write decode; ascending port scan lets the highest valid port win.
    always_comb begin
        w_wr_hit = '0;
        for (int unsigned a = 0; a < NREGS; a++) begin
            w_wr_data[a] = '0;
        end
        for (int unsigned j = 0; j < WRITE_PORTS; j++) begin
            if (wvalid[j] && (wa[j] != '0)) begin
                w_wr_hit[wa[j]]  = 1'b1;
                w_wr_data[wa[j]] = wd[j];
            end
        end
    end

    always_comb begin
        w_resv_hit = '0;
        for (int unsigned k = 0; k < RESV_PORTS; k++) begin
            if (resv_valid[k] && (resv_addr[k] != '0)) begin
                w_resv_hit[resv_addr[k]] = 1'b1;
            end
        end
    end

    always_comb begin
        rd1    = '0;
        rd2    = '0;
        rbusy1 = '0;
        rbusy2 = '0;
        for (int unsigned i = 0; i < READ_PORTS; i++) begin
            if (ra1[i] != '0) begin
                rd1[i]    = w_wr_hit[ra1[i]] ? w_wr_data[ra1[i]] : r_mem[ra1[i]];
                rbusy1[i] = r_busy[ra1[i]] & ~w_wr_hit[ra1[i]];
            end
            if (ra2[i] != '0) begin
                rd2[i]    = w_wr_hit[ra2[i]] ? w_wr_data[ra2[i]] : r_mem[ra2[i]];
                rbusy2[i] = r_busy[ra2[i]] & ~w_wr_hit[ra2[i]];
            end
        end
    end

    // A reservation overrides a same-cycle writeback clear; flush overrides both.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned a = 0; a < NREGS; a++) begin
                r_mem[a] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int unsigned a = 1; a < NREGS; a++) begin
                if (w_wr_hit[a]) begin
                    r_mem[a] <= w_wr_data[a];
                end
            end
            if (flush) begin
                r_busy <= '0;
            end else begin
                r_busy <= (r_busy & ~w_wr_hit) | w_resv_hit;
            end
        end
    end

    assign busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus randomized traffic against a
// behavioural model of register contents and pending destinations.
module tb_regfile_sb;

    localparam int RP = 2;
    localparam int WP = 2;
    localparam int VP = 2;
    localparam int NR = 32;
    localparam int XL = 64;
    localparam int AW = 5;

    logic                   clk;
    logic                   reset;
    logic [RP-1:0][AW-1:0]  ra1, ra2;
    logic [RP-1:0][XL-1:0]  rd1, rd2;
    logic [RP-1:0]          rbusy1, rbusy2;
    logic [WP-1:0][AW-1:0]  wa;
    logic [WP-1:0]          wvalid;
    logic [WP-1:0][XL-1:0]  wd;
    logic [VP-1:0][AW-1:0]  resv_addr;
    logic [VP-1:0]          resv_valid;
    logic                   flush;
    logic [NR-1:0]          busy_vec;

    regfile_sb #(
        .READ_PORTS (RP),
        .WRITE_PORTS(WP),
        .RESV_PORTS (VP),
        .NREGS      (NR),
        .XLEN       (XL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1       (rd1),
        .rd2       (rd2),
        .rbusy1    (rbusy1),
        .rbusy2    (rbusy2),
        .wa        (wa),
        .wvalid    (wvalid),
        .wd        (wd),
        .resv_addr (resv_addr),
        .resv_valid(resv_valid),
        .flush     (flush),
        .busy_vec  (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [XL-1:0] m_mem  [NR];
    bit            m_busy [NR];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [XL-1:0] got, input logic [XL-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Value a reader sees: register 0 is zero, otherwise the last valid write port
    // naming this register this cycle, otherwise the stored contents.
    function automatic logic [XL-1:0] exp_rd(input logic [AW-1:0] a);
        logic [XL-1:0] v;
        if (a == 0) return '0;
        v = m_mem[a];
        for (int j = 0; j < WP; j++)
            if (wvalid[j] && wa[j] == a) v = wd[j];
        return v;
    endfunction

    function automatic logic exp_rbusy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        for (int j = 0; j < WP; j++)
            if (wvalid[j] && wa[j] == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [NR-1:0] exp_busy_vec();
        logic [NR-1:0] v;
        for (int a = 0; a < NR; a++) v[a] = m_busy[a];
        return v;
    endfunction

    task automatic idle();
        ra1 = '0; ra2 = '0; wa = '0; wvalid = '0; wd = '0;
        resv_addr = '0; resv_valid = '0; flush = 1'b0; reset = 1'b0;
    endtask

    task automatic settle();
        #1;
        for (int i = 0; i < RP; i++) begin
            check($sformatf("rd1[%0d]", i), rd1[i], exp_rd(ra1[i]));
            check($sformatf("rd2[%0d]", i), rd2[i], exp_rd(ra2[i]));
            check($sformatf("rbusy1[%0d]", i), XL'(rbusy1[i]), XL'(exp_rbusy(ra1[i])));
            check($sformatf("rbusy2[%0d]", i), XL'(rbusy2[i]), XL'(exp_rbusy(ra2[i])));
        end
        check("busy_vec", XL'(busy_vec), XL'(exp_busy_vec()));
    endtask

    // Clock edge: advance the model with the inputs currently applied.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int a = 0; a < NR; a++) begin
                m_mem[a]  = '0;
                m_busy[a] = 0;
            end
        end else begin
            for (int j = 0; j < WP; j++)
                if (wvalid[j] && wa[j] != 0) begin
                    m_mem[wa[j]]  = wd[j];
                    m_busy[wa[j]] = 0;
                end
            for (int k = 0; k < VP; k++)
                if (resv_valid[k] && resv_addr[k] != 0) m_busy[resv_addr[k]] = 1;
            if (flush)
                for (int a = 0; a < NR; a++) m_busy[a] = 0;
        end
        #1;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR-1));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        reset = 1'b1;
        @(negedge clk);
        tick();
        idle();

        // Post-reset state on a spread of addresses
        ra1[0] = 5'd0; ra1[1] = 5'd1; ra2[0] = 5'd17; ra2[1] = 5'd31;
        settle();
        check("post_reset_rd", rd2[1], '0);
        check("post_reset_busy", XL'(busy_vec), '0);
        tick();

        // Write-through bypass and persistence
        idle();
        wvalid[0] = 1'b1; wa[0] = 5'd5; wd[0] = 64'hDEAD; ra1[0] = 5'd5;
        settle();
        check("bypass_x5", rd1[0], 64'hDEAD);
        tick();
        idle(); ra1[0] = 5'd5;
        settle();
        check("stored_x5", rd1[0], 64'hDEAD);
        tick();

        // Same-address write priority, and writes to x0 discarded
        idle();
        wvalid = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 64'h11; wd[1] = 64'h22;
        ra1[0] = 5'd7;
        settle();
        check("prio_bypass_x7", rd1[0], 64'h22);
        tick();
        idle();
        wvalid[0] = 1'b1; wa[0] = 5'd0; wd[0] = 64'hFF; ra1[0] = 5'd7; ra2[0] = 5'd0;
        settle();
        check("prio_x7", rd1[0], 64'h22);
        check("x0_bypass", rd2[0], '0);
        tick();
        idle(); ra2[0] = 5'd0;
        settle();
        check("x0_stored", rd2[0], '0);
        tick();

        // Reserve, observe busy, release by writeback
        idle(); resv_valid[0] = 1'b1; resv_addr[0] = 5'd3; ra1[0] = 5'd3;
        settle();
        check("resv_not_same_cycle", XL'(rbusy1[0]), '0);
        tick();
        idle(); ra1[0] = 5'd3;
        settle();
        check("busy_x3_c1", XL'(busy_vec[3]), 64'd1);
        check("rbusy_x3_c1", XL'(rbusy1[0]), 64'd1);
        tick();
        idle(); ra1[0] = 5'd3; wvalid[1] = 1'b1; wa[1] = 5'd3; wd[1] = 64'h5;
        settle();
        check("rbusy_x3_wr", XL'(rbusy1[0]), '0);
        check("busy_x3_wr", XL'(busy_vec[3]), 64'd1);
        tick();
        idle(); ra1[0] = 5'd3;
        settle();
        check("busy_x3_c3", XL'(busy_vec[3]), '0);
        check("data_x3", rd1[0], 64'h5);
        tick();

        // Same-cycle reserve and write: data commits, stays busy
        idle(); resv_valid[1] = 1'b1; resv_addr[1] = 5'd9;
        wvalid[0] = 1'b1; wa[0] = 5'd9; wd[0] = 64'h42;
        settle();
        tick();
        idle(); ra1[0] = 5'd9;
        settle();
        check("x9_data", rd1[0], 64'h42);
        check("x9_busy", XL'(busy_vec[9]), 64'd1);
        tick();

        // Flush overrides a same-cycle reservation; x0 never reservable
        idle(); resv_valid = 2'b11; resv_addr[0] = 5'd1; resv_addr[1] = 5'd2;
        settle(); tick();
        idle(); resv_valid = 2'b11; resv_addr[0] = 5'd3; resv_addr[1] = 5'd4;
        settle(); tick();
        idle();
        settle();
        check("busy_x1_x4", XL'(busy_vec[4:1]), 64'hF);
        flush = 1'b1; resv_valid[0] = 1'b1; resv_addr[0] = 5'd6;
        settle(); tick();
        idle();
        settle();
        check("flush_busy", XL'(busy_vec), '0);
        resv_valid[0] = 1'b1; resv_addr[0] = 5'd0;
        settle(); tick();
        idle();
        settle();
        check("resv_x0", XL'(busy_vec[0]), '0);
        tick();

        // Reset with an outstanding reservation
        idle(); resv_valid[0] = 1'b1; resv_addr[0] = 5'd2;
        wvalid[0] = 1'b1; wa[0] = 5'd2; wd[0] = 64'h77;
        settle(); tick();
        idle(); ra1[0] = 5'd2;
        settle();
        check("x2_pre_reset", rd1[0], 64'h77);
        check("x2_busy_pre_reset", XL'(busy_vec[2]), 64'd1);
        reset = 1'b1; flush = 1'b0;
        resv_valid[1] = 1'b1; resv_addr[1] = 5'd8;
        wvalid[1] = 1'b1; wa[1] = 5'd8; wd[1] = 64'h99;
        tick();
        idle(); ra1[0] = 5'd2; ra2[1] = 5'd8;
        settle();
        check("x2_reset", rd1[0], '0);
        check("x8_reset", rd2[1], '0);
        check("busy_reset", XL'(busy_vec), '0);
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            for (int i = 0; i < RP; i++) begin
                ra1[i] = rnd_addr();
                ra2[i] = rnd_addr();
            end
            for (int j = 0; j < WP; j++) begin
                wvalid[j] = ($urandom_range(0, 2) != 0);
                wa[j]     = rnd_addr();
                wd[j]     = {$urandom, $urandom};
            end
            for (int k = 0; k < VP; k++) begin
                resv_valid[k] = ($urandom_range(0, 1) != 0);
                resv_addr[k]  = rnd_addr();
            end
            flush = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 199) == 0);
            settle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
